// File: rtl/hex_disp_pkg.sv
// Shared definitions for the multiplexed hex display driver/decoder pair:
// segment pattern table, decoder FSM states and digit geometry.
package hex_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

  // Active-low a..g patterns indexed by nibble; bit 7 (dp) shown unlit.
  localparam logic [15:0][SEG_W-1:0] SEG_PATTERNS = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // Index of the (single) low bit of an active-low one-hot grid.
  function automatic logic [1:0] grid_to_idx(input logic [NUM_DIGITS-1:0] grid_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (!grid_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational 7-segment (active-low a..g) to nibble decoder; err flags
// any pattern that is not one of the sixteen hex glyphs.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [6:0]       seg_i,
  output logic [NIB_W-1:0] nib_c_o,
  output logic             err_c_o
);

  always_comb begin
    nib_c_o = '0;
    err_c_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_PATTERNS[i][6:0]) begin
        nib_c_o = NIB_W'(i);
        err_c_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hex_display_decoder.sv
// Reads back a multiplexed 4-digit hex display: registers the grid/segment
// bus, debounces each digit, decodes it and publishes whole scan frames.
module hex_display_decoder
  import hex_disp_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NUM_DIGITS-1:0] hex_grid,
  input  logic [SEG_W-1:0]      hex_seg,
  output logic [VALUE_W-1:0]    value,
  output logic [NUM_DIGITS-1:0] dp,
  output logic                  value_valid,
  output logic                  changed,
  output logic                  seg_err,
  output logic                  stale
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_DIGITS-1:0] grid_q, grid_p_q;
  logic [SEG_W-1:0]      seg_q, seg_p_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  state_t                state_q, state_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [VALUE_W-1:0]    nib_q, nib_d;
  logic [NUM_DIGITS-1:0] dpc_q, dpc_d;
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [VALUE_W-1:0]    value_q, value_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic                  valid_q, valid_d;
  logic                  changed_q, changed_d;
  logic                  seg_err_q, seg_err_d;
  logic                  stale_q, stale_d;

  logic                  same_c, grid_ok_c, accept_c;
  logic [1:0]            idx_c;
  logic [NIB_W-1:0]      dec_nib_c;
  logic                  dec_err_c;

  hex_seg_decode u_dec (
    .seg_i   (seg_q[6:0]),
    .nib_c_o (dec_nib_c),
    .err_c_o (dec_err_c)
  );

  // Stability filter: one acceptance per run of identical valid samples.
  always_comb begin
    same_c    = (grid_q == grid_p_q) && (seg_q == seg_p_q);
    grid_ok_c = $onehot(~grid_q);
    idx_c     = grid_to_idx(grid_q);
    cnt_d     = '0;
    done_d    = 1'b0;
    accept_c  = 1'b0;
    if (grid_ok_c) begin
      if (same_c) cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
      accept_c = (cnt_d == CNT_LAST) && !(same_c && done_q);
      done_d   = accept_c || (same_c && done_q);
    end
  end

  // Frame assembly FSM: next state and all registered outputs.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    nib_d     = nib_q;
    dpc_d     = dpc_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    value_d   = value_q;
    dp_d      = dp_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    seg_err_d = seg_err_q;
    stale_d   = stale_q;

    case (state_q)
      HUNT: begin
        if (accept_c) begin
          nib_d[{idx_c, 2'b00} +: NIB_W] = dec_nib_c;
          dpc_d[idx_c]  = ~seg_q[SEG_W-1];
          err_d[idx_c]  = dec_err_c;
          mask_d[idx_c] = 1'b1;
          tmo_d         = '0;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        // Timeout wins over a digit accepted in the same cycle.
        if (tmo_q == TMO_LAST) begin
          stale_d = 1'b1;
          mask_d  = '0;
          err_d   = '0;
          state_d = HUNT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (accept_c) begin
            nib_d[{idx_c, 2'b00} +: NIB_W] = dec_nib_c;
            dpc_d[idx_c]  = ~seg_q[SEG_W-1];
            err_d[idx_c]  = dec_err_c;
            mask_d[idx_c] = 1'b1;
            if (mask_d == '1) state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        value_d   = nib_q;
        dp_d      = dpc_q;
        seg_err_d = |err_q;
        changed_d = (nib_q != value_q);
        valid_d   = 1'b1;
        stale_d   = 1'b0;
        mask_d    = '0;
        err_d     = '0;
        state_d   = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grid_q    <= '1;
      seg_q     <= '1;
      grid_p_q  <= '1;
      seg_p_q   <= '1;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      state_q   <= HUNT;
      mask_q    <= '0;
      nib_q     <= '0;
      dpc_q     <= '0;
      err_q     <= '0;
      tmo_q     <= '0;
      value_q   <= '0;
      dp_q      <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      seg_err_q <= 1'b0;
      stale_q   <= 1'b1;
    end else begin
      grid_q    <= hex_grid;
      seg_q     <= hex_seg;
      grid_p_q  <= grid_q;
      seg_p_q   <= seg_q;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      state_q   <= state_d;
      mask_q    <= mask_d;
      nib_q     <= nib_d;
      dpc_q     <= dpc_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      value_q   <= value_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      seg_err_q <= seg_err_d;
      stale_q   <= stale_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign value_valid = valid_q;
  assign changed     = changed_q;
  assign seg_err     = seg_err_q;
  assign stale       = stale_q;

endmodule
